uart_rx_frontend: RTL and testbench
===================================

Name: uart_rx_frontend

Overview:
- Serial byte receiver that feeds the LED panel command parser. It delivers one byte per UART frame, with a single-cycle valid strobe.
- Input format: asynchronous 8N1 UART line, LSB first, idle high.
- Robustness features: input synchroniser, start-bit glitch rejection, 3-sample majority vote per bit, framing-error and break reporting.
- Sits directly upstream of the panel's command state machine. rx_dv/rx_data connect straight to its uart_rx_dv/uart_rx_data inputs.

Parameters:
- CLKS_PER_BIT, 20, clk cycles per UART bit. Legal range 8..255.
- HALF_BIT, (CLKS_PER_BIT-1)/2, derived (localparam). clk_cnt value at which the start bit is re-checked.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- rx_serial  in  1  asynchronous UART line, idle high
- rx_dv  out  1  one-cycle strobe: rx_data holds a valid new byte
- rx_data  out  8  last correctly received byte (bit 0 = first data bit)
- frame_err  out  1  one-cycle strobe: stop bit sampled low
- rx_break  out  1  one-cycle strobe, coincident with frame_err when all data bits were 0
- busy  out  1  high in every state except IDLE

Behaviour:
- One clock, clk. Reset is synchronous and active-high. All state is updated on posedge clk.
- Reset values:
  - rx_dv=0, frame_err=0, rx_break=0, busy=0, rx_data=8'h00.
  - Synchroniser flops = 1. State = IDLE. clk_cnt=0, bit_idx=0, shift register=0.
- Synchroniser: 2 flops on rx_serial; rxs = second flop. All logic below uses rxs only.
- Vote: 3-bit history of rxs, captured at clk_cnt = C-3, C-2, C-1 (C = CLKS_PER_BIT). Bit value = majority of the three samples.
- States and transitions:
  - IDLE: when rxs==0 -> START, clk_cnt<=0.
  - START: clk_cnt increments each cycle. At clk_cnt==HALF_BIT:
    - rxs==0 -> DATA, clk_cnt<=0, bit_idx<=0.
    - rxs==1 -> IDLE. This is a glitch; no strobe is raised.
  - DATA: clk_cnt counts 0..C-1. At C-1 the vote result is shifted in MSB-side with a right shift, so the first bit ends at bit 0. clk_cnt<=0.
    - bit_idx==7 -> STOP.
    - otherwise bit_idx+1.
  - STOP: at clk_cnt==C-1, vote result applies:
    - 1 -> rx_data<=shift register, rx_dv<=1, -> IDLE.
    - 0 -> frame_err<=1; rx_break<=1 if shift register==0; rx_data unchanged; -> WAIT_IDLE.
  - WAIT_IDLE: stay until rxs==1, then -> IDLE. Holding the line low (break) produces exactly one frame_err.
- Strobes: rx_dv, frame_err and rx_break are registered and high for exactly one cycle. rx_dv and frame_err are never high together.
- Latency: let t0 be the first edge at which rxs==0 is seen in IDLE.
  - rx_dv is high in cycle t0+2+HALF_BIT+9*C.
  - For C=20 this is t0+191.
  - rxs lags rx_serial by 2 clocks.
- Back-to-back frames: IDLE is re-entered at the stop-bit centre. A start edge arriving half a bit later is accepted with no lost frames.
- Counters: clk_cnt is 8 bits and bit_idx is 3 bits. Neither counter ever wraps within a state.
- Reset asserted mid-frame: all state returns to reset values on the next edge, and no strobe is emitted. After reset, a line that is still low is treated as a new start edge. Starting mid-frame gives garbage or frame_err, which is acceptable.
- There is no flow control. The consumer must take rx_data in the rx_dv cycle. rx_data stays stable until the next rx_dv.

Decomposition:
- Shared package uart_pkg holds:
  - the state enum (IDLE, START, DATA, STOP, WAIT_IDLE), 3 bits;
  - CLKS_PER_BIT_DEFAULT=20;
  - panel command opcodes (0x0 colour, 0x1 set, 0x2 clr, 0x3 cls, 0xF reset), so parser and testbench share them.
- Sub-module bit_sync: a 2-flop synchroniser with parameterised reset value (1 here). It is reused for any other async input.

Test Plan:
- Send 0xA5 at C=20, clean line -> one rx_dv pulse, rx_data=8'hA5, at t0+191. frame_err stays 0. busy is high from t0+1 until rx_dv.
- Send 0x10 then 0x3C back-to-back, stop bit width 1.0 -> two rx_dv pulses 200 cycles apart, data 0x10 then 0x3C.
- Glitch: rx_serial low for 5 cycles, then high -> returns to IDLE. No rx_dv and no frame_err. A following 0x01 is received correctly.
- Stop bit forced low on frame 0x55 -> frame_err=1 for one cycle, rx_break=0, rx_data keeps its previous value. After the line goes high and a valid 0x22 is sent, rx_dv=1 with rx_data=0x22.
- Line held low for 30 bit times -> exactly one frame_err+rx_break pulse. No rx_dv. busy stays high until the line returns high.
- Single-cycle inverted pulse placed at the sample C-2 of each data bit while sending 0x81 -> majority vote rejects it, and rx_data=0x81. Assert reset in the middle of the next frame -> all outputs are at reset values the next cycle, with no strobes.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path and the LED panel command parser.
package uart_pkg;

  // Receiver FSM states.
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_IDLE = 3'd4
  } uart_state_e;

  localparam int CLKS_PER_BIT_DEFAULT = 20;

  // Panel command opcodes (low nibble of the first command byte).
  localparam logic [3:0] OP_COLOUR = 4'h0;
  localparam logic [3:0] OP_SET    = 4'h1;
  localparam logic [3:0] OP_CLR    = 4'h2;
  localparam logic [3:0] OP_CLS    = 4'h3;
  localparam logic [3:0] OP_RESET  = 4'hF;

  // Majority of three samples.
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/bit_sync.sv
// Two-flop synchroniser for a single asynchronous input.
module bit_sync #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic async_i,
  output logic sync_o
);

  logic meta_q;
  logic sync_q;

  // Shift the async input through two flops; both start at RESET_VAL.
  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
    end
  end

  assign sync_o = sync_q;

endmodule

// File: rtl/uart_rx_frontend.sv
// 8N1 UART receiver: synchroniser, start-bit glitch rejection, 3-sample
// majority vote per bit, framing-error and break reporting.
//
// Output handshake: rx_dv is a one-cycle valid strobe with no ready; the
// consumer must take rx_data in that cycle. rx_data then holds until the next
// rx_dv. frame_err (and rx_break with it) is a separate one-cycle strobe that
// never coincides with rx_dv.
module uart_rx_frontend
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_serial,
  output logic        rx_dv,
  output logic [7:0]  rx_data,
  output logic        frame_err,
  output logic        rx_break,
  output logic        busy,
  output uart_state_e dbg_state
);

  localparam logic [7:0] HALF_BIT = 8'((CLKS_PER_BIT - 1) / 2);
  localparam logic [7:0] LAST     = 8'(CLKS_PER_BIT - 1);
  localparam logic [7:0] SMP_A    = 8'(CLKS_PER_BIT - 3);
  localparam logic [7:0] SMP_B    = 8'(CLKS_PER_BIT - 2);

  logic        rxs;
  uart_state_e state_q, state_d;
  logic [7:0]  clk_cnt_q, clk_cnt_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  shift_q, shift_d;
  logic [1:0]  hist_q, hist_d;
  logic [7:0]  rx_data_q, rx_data_d;
  logic        rx_dv_q, rx_dv_d;
  logic        frame_err_q, frame_err_d;
  logic        rx_break_q, rx_break_d;
  logic        vote;

  bit_sync #(.RESET_VAL(1'b1)) u_sync (
    .clk     (clk),
    .reset   (reset),
    .async_i (rx_serial),
    .sync_o  (rxs)
  );

  // The samples at C-3 and C-2 are held in hist_q; the third (C-1) sample is
  // the live rxs in the cycle the vote is consumed.
  assign vote = maj3(hist_q[1], hist_q[0], rxs);

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      clk_cnt_q   <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      hist_q      <= '0;
      rx_data_q   <= '0;
      rx_dv_q     <= 1'b0;
      frame_err_q <= 1'b0;
      rx_break_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      clk_cnt_q   <= clk_cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      hist_q      <= hist_d;
      rx_data_q   <= rx_data_d;
      rx_dv_q     <= rx_dv_d;
      frame_err_q <= frame_err_d;
      rx_break_q  <= rx_break_d;
    end
  end

  // Next-state, counters, vote history and strobes.
  always_comb begin
    state_d     = state_q;
    clk_cnt_d   = clk_cnt_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    hist_d      = hist_q;
    rx_data_d   = rx_data_q;
    rx_dv_d     = 1'b0;
    frame_err_d = 1'b0;
    rx_break_d  = 1'b0;

    if ((state_q == DATA || state_q == STOP) &&
        (clk_cnt_q == SMP_A || clk_cnt_q == SMP_B)) begin
      hist_d = {hist_q[0], rxs};
    end

    unique case (state_q)
      IDLE: begin
        if (!rxs) begin
          state_d   = START;
          clk_cnt_d = '0;
        end
      end
      START: begin
        if (clk_cnt_q == HALF_BIT) begin
          clk_cnt_d = '0;
          if (!rxs) begin
            state_d   = DATA;
            bit_idx_d = '0;
          end else begin
            state_d = IDLE;  // start bit did not survive: glitch, no strobe
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 8'd1;
        end
      end
      DATA: begin
        if (clk_cnt_q == LAST) begin
          clk_cnt_d = '0;
          shift_d   = {vote, shift_q[7:1]};  // LSB first: first bit lands at bit 0
          if (bit_idx_q == 3'd7) begin
            state_d = STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 8'd1;
        end
      end
      STOP: begin
        if (clk_cnt_q == LAST) begin
          clk_cnt_d = '0;
          if (vote) begin
            rx_data_d = shift_q;
            rx_dv_d   = 1'b1;
            state_d   = IDLE;  // back at stop-bit centre, ready for the next edge
          end else begin
            frame_err_d = 1'b1;
            rx_break_d  = (shift_q == 8'h00);
            state_d     = WAIT_IDLE;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 8'd1;
        end
      end
      WAIT_IDLE: begin
        if (rxs) begin
          state_d = IDLE;  // a held-low line reports only one error
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign rx_dv     = rx_dv_q;
  assign rx_data   = rx_data_q;
  assign frame_err = frame_err_q;
  assign rx_break  = rx_break_q;
  assign busy      = (state_q != IDLE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_uart_rx_frontend.sv
// Directed bench for uart_rx_frontend at CLKS_PER_BIT = 20.
module tb_uart_rx_frontend;
  import uart_pkg::*;

  localparam int C    = CLKS_PER_BIT_DEFAULT;
  localparam int HALF = (C - 1) / 2;
  // Line falls at a negedge after posedge N; two sync flops put the FSM's
  // first look at edge N+3 (t0); rx_dv is registered at edge t0+1+HALF+9*C
  // and seen at the following negedge.
  localparam int LAT  = 4 + HALF + 9 * C;
  // Offset within a data bit at which a one-cycle line pulse reaches the
  // receiver exactly at its C-2 sample.
  localparam int GOFF = HALF;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rx_serial = 1'b1;
  logic        rx_dv;
  logic [7:0]  rx_data;
  logic        frame_err;
  logic        rx_break;
  logic        busy;
  uart_state_e dbg_state;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Monitor records
  int dv_cnt = 0, fe_cnt = 0, brk_cnt = 0, both_cnt = 0;
  int busy_rise_cyc = -1, busy_fall_cyc = -1;
  logic prev_busy = 1'b0;
  logic [7:0] dv_data_q[$];
  int         dv_cyc_q[$];
  logic [7:0] exp_q[$];

  uart_rx_frontend #(.CLKS_PER_BIT(C)) dut (
    .clk       (clk),
    .reset     (reset),
    .rx_serial (rx_serial),
    .rx_dv     (rx_dv),
    .rx_data   (rx_data),
    .frame_err (frame_err),
    .rx_break  (rx_break),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // Clock and cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (!reset) begin
      if (rx_dv) begin
        dv_cnt++;
        dv_data_q.push_back(rx_data);
        dv_cyc_q.push_back(cyc);
      end
      if (frame_err) fe_cnt++;
      if (rx_break) brk_cnt++;
      if (rx_dv && frame_err) both_cnt++;
      if (busy && !prev_busy) busy_rise_cyc = cyc;
      if (!busy && prev_busy) busy_fall_cyc = cyc;
      prev_busy = busy;
    end else begin
      prev_busy = 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    rx_serial = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_bit(input logic v);
    rx_serial = v;
    repeat (C) @(negedge clk);
  endtask

  task automatic drive_bit_glitch(input logic v);
    rx_serial = v;
    repeat (GOFF) @(negedge clk);
    rx_serial = ~v;
    @(negedge clk);
    rx_serial = v;
    repeat (C - GOFF - 1) @(negedge clk);
  endtask

  // Drives one frame starting at a negedge; returns the cycle of the start edge.
  task automatic send_frame(input logic [7:0] b, input logic stop, input logic glitch,
                            output int start_cyc);
    start_cyc = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) begin
      if (glitch) drive_bit_glitch(b[i]);
      else        drive_bit(b[i]);
    end
    drive_bit(stop);
  endtask

  // Scoreboard: compare every received byte with the expected queue.
  task automatic drain(input string tag);
    chk({tag, "_count"}, 32'(dv_data_q.size()), 32'(exp_q.size()));
    while (dv_data_q.size() > 0 && exp_q.size() > 0) begin
      chk({tag, "_data"}, 32'(dv_data_q.pop_front()), 32'(exp_q.pop_front()));
    end
    dv_data_q.delete();
    exp_q.delete();
    dv_cyc_q.delete();
  endtask

  initial begin
    int s0, s1, dv0, fe0, brk0;

    // Reset state
    repeat (4) @(negedge clk);
    chk("rst_dv", 32'(rx_dv), 32'd0);
    chk("rst_fe", 32'(frame_err), 32'd0);
    chk("rst_brk", 32'(rx_break), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_data", 32'(rx_data), 32'h00);
    chk("rst_state", 32'(dbg_state), 32'(IDLE));
    reset = 1'b0;
    idle(10);

    // 0xA5, clean line: latency and busy window
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1, 1'b0, s0);
    idle(20);
    chk("a5_lat", 32'(dv_cyc_q.size() > 0 ? dv_cyc_q[0] : -1), 32'(s0 + LAT));
    chk("a5_busy_rise", 32'(busy_rise_cyc), 32'(s0 + 3));
    chk("a5_busy_fall", 32'(busy_fall_cyc), 32'(s0 + LAT));
    chk("a5_fe", 32'(fe_cnt), 32'd0);
    drain("a5");

    // 0x10 then 0x3C back-to-back with a one-bit stop
    exp_q.push_back(8'h10);
    exp_q.push_back(8'h3C);
    send_frame(8'h10, 1'b1, 1'b0, s0);
    send_frame(8'h3C, 1'b1, 1'b0, s1);
    idle(20);
    chk("b2b_gap", 32'(dv_cyc_q.size() > 1 ? dv_cyc_q[1] - dv_cyc_q[0] : -1), 32'(10 * C));
    chk("b2b_lat2", 32'(dv_cyc_q.size() > 1 ? dv_cyc_q[1] : -1), 32'(s1 + LAT));
    drain("b2b");

    // Start-bit glitch of 5 cycles, then 0x01
    dv0 = dv_cnt; fe0 = fe_cnt;
    rx_serial = 1'b0;
    repeat (5) @(negedge clk);
    idle(30);
    chk("gl_dv", 32'(dv_cnt - dv0), 32'd0);
    chk("gl_fe", 32'(fe_cnt - fe0), 32'd0);
    chk("gl_state", 32'(dbg_state), 32'(IDLE));
    exp_q.push_back(8'h01);
    send_frame(8'h01, 1'b1, 1'b0, s0);
    idle(20);
    drain("gl_01");

    // Framing error on 0x55, then 0x22
    dv0 = dv_cnt; fe0 = fe_cnt; brk0 = brk_cnt;
    send_frame(8'h55, 1'b0, 1'b0, s0);
    idle(40);
    chk("fe_pulse", 32'(fe_cnt - fe0), 32'd1);
    chk("fe_brk", 32'(brk_cnt - brk0), 32'd0);
    chk("fe_dv", 32'(dv_cnt - dv0), 32'd0);
    chk("fe_hold", 32'(rx_data), 32'h01);
    exp_q.push_back(8'h22);
    send_frame(8'h22, 1'b1, 1'b0, s0);
    idle(20);
    drain("fe_22");

    // Line held low for 30 bit times: one break report
    dv0 = dv_cnt; fe0 = fe_cnt; brk0 = brk_cnt;
    rx_serial = 1'b0;
    repeat (30 * C) @(negedge clk);
    chk("brk_busy_low", 32'(busy), 32'd1);
    chk("brk_state", 32'(dbg_state), 32'(WAIT_IDLE));
    idle(5);
    chk("brk_busy_rel", 32'(busy), 32'd0);
    chk("brk_fe", 32'(fe_cnt - fe0), 32'd1);
    chk("brk_brk", 32'(brk_cnt - brk0), 32'd1);
    chk("brk_dv", 32'(dv_cnt - dv0), 32'd0);
    idle(20);

    // 0x81 with a one-cycle inverted pulse on each data bit's C-2 sample
    exp_q.push_back(8'h81);
    send_frame(8'h81, 1'b1, 1'b1, s0);
    idle(20);
    drain("vote_81");
    chk("never_both", 32'(both_cnt), 32'd0);

    // Reset in the middle of the next frame
    dv0 = dv_cnt; fe0 = fe_cnt;
    fork
      send_frame(8'h3C, 1'b1, 1'b0, s0);
      begin
        repeat (80) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("mr_dv", 32'(rx_dv), 32'd0);
        chk("mr_fe", 32'(frame_err), 32'd0);
        chk("mr_brk", 32'(rx_break), 32'd0);
        chk("mr_busy", 32'(busy), 32'd0);
        chk("mr_data", 32'(rx_data), 32'h00);
        chk("mr_state", 32'(dbg_state), 32'(IDLE));
        chk("mr_nostrobe", 32'((dv_cnt - dv0) + (fe_cnt - fe0)), 32'd0);
        reset = 1'b0;
      end
    join
    idle(300);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
